// File: rtl/aes_if.sv
// Block-level handshake bundle for the AES core: request side, result side.
// The key width follows the instance's key size.
interface aes_if #(
  parameter int unsigned N = 128
);
  logic         start;
  logic [127:0] in;
  logic [N-1:0] key;
  logic [127:0] out;
  logic         done;
  logic         busy;

  modport master (output start, output in, output key, input out, input done, input busy);
  modport slave  (input start, input in, input key, output out, output done, output busy);
endinterface

// File: rtl/aes.sv
// Iterative AES-128/192/256 encryption core: one round per clock, full key schedule
// derived combinationally from the key captured at start.
module aes #(
  parameter int unsigned N  = 128,
  parameter int unsigned Nr = 10,
  parameter int unsigned Nk = 4
) (
  input logic  clk,
  input logic  rst,
  aes_if.slave bus
);

  localparam int unsigned NW = 4 * (Nr + 1);
  localparam int unsigned RkW = 128 * (Nr + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Row-major 16x16 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Round key r lands at bits [128*r +: 128], word 4r in its top 32 bits.
  function automatic logic [RkW-1:0] expand(input logic [N-1:0] k);
    logic [31:0]    w [NW];
    logic [31:0]    t;
    logic [7:0]     rcon;
    logic [RkW-1:0] rk;
    rcon = 8'h01;
    rk   = '0;
    for (int i = 0; i < int'(NW); i++) begin
      if (i < int'(Nk)) begin
        w[i] = k[int'(N) - 1 - 32 * i -: 32];
      end else begin
        t = w[i-1];
        if (i % int'(Nk) == 0) begin
          t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
          rcon = xtime(rcon);
        end else if (Nk > 6 && i % int'(Nk) == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i - int'(Nk)] ^ t;
      end
      rk[128 * (i / 4) + 32 * (3 - i % 4) +: 32] = w[i];
    end
    return rk;
  endfunction

  function automatic logic [127:0] do_round(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [7:0]   b  [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) begin
      b[k] = sbox(s[127 - 8 * k -: 8]);
    end
    // Byte (row, col) sits at index 4*col + row; row n rotates left by n.
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 4; n++) begin
        sr[4 * c + n] = b[4 * ((c + n) % 4) + n];
      end
    end
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4 * c];
      a1 = sr[4 * c + 1];
      a2 = sr[4 * c + 2];
      a3 = sr[4 * c + 3];
      if (last) begin
        r[127 - 32 * c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127 - 32 * c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r ^ rk;
  endfunction

  logic [0:0]     st_q, st_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   out_q, out_d;
  logic [N-1:0]   key_q, key_d;
  logic           done_q, done_d;
  logic [RkW-1:0] rkeys;
  logic [127:0]   rnd;

  assign rkeys = expand(key_q);
  assign rnd   = do_round(state_q, rkeys[128 * int'(cnt_q) +: 128], cnt_q == 4'(Nr));

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    out_d   = out_q;
    key_d   = key_q;
    done_d  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          // Round key 0 is simply the leading 128 key bits.
          state_d = bus.in ^ bus.key[N-1 -: 128];
          key_d   = bus.key;
          cnt_d   = 4'd1;
          st_d    = RUN;
        end
      end
      RUN: begin
        state_d = rnd;
        if (cnt_q == 4'(Nr)) begin
          out_d  = rnd;
          done_d = 1'b1;
          cnt_d  = 4'd0;
          st_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      out_q   <= '0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      out_q   <= out_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.done = done_q;
  assign bus.busy = (st_q == RUN);

endmodule

// File: tb/tb_aes.sv
// Randomised self-checking bench for the AES core at all three key sizes, against
// a byte-array reference cipher with a field-arithmetic S-box.
module tb_aes;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_if #(.N(128)) b128 ();
  aes_if #(.N(192)) b192 ();
  aes_if #(.N(256)) b256 ();

  aes #(.N(128), .Nr(10), .Nk(4)) u128 (.clk(clk), .rst(rst), .bus(b128));
  aes #(.N(192), .Nr(12), .Nk(6)) u192 (.clk(clk), .rst(rst), .bus(b192));
  aes #(.N(256), .Nr(14), .Nk(8)) u256 (.clk(clk), .rst(rst), .bus(b256));

  int n_pass  = 0;
  int n_total = 0;
  int dcnt [3] = '{0, 0, 0};

  logic [7:0]   sb_t [256];
  logic [127:0] q_pt  [$];
  logic [127:0] q_exp [$];
  logic [255:0] q_key [$];

  always @(negedge clk) begin
    if (b128.done) dcnt[0]++;
    if (b192.done) dcnt[1]++;
    if (b256.done) dcnt[2]++;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb_t[v[31:24]], sb_t[v[23:16]], sb_t[v[15:8]], sb_t[v[7:0]]};
  endfunction

  // Key is right-aligned in k, 32*nk bits wide.
  function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [255:0] k,
                                             input int nk);
    int           nr = nk + 6;
    logic [31:0]  w [60];
    logic [31:0]  tmp;
    logic [7:0]   rc = 8'h01;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int i = 0; i < nk; i++) w[i] = k[32 * (nk - i) - 1 -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127 - 8 * j -: 8] ^ w[j / 4][31 - 8 * (j % 4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++) t[j] = sb_t[s[j]];
      for (int c = 0; c < 4; c++)
        for (int n = 0; n < 4; n++) s[4 * c + n] = t[4 * ((c + n) % 4) + n];
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int n = 0; n < 4; n++) a[n] = s[4 * c + n];
          for (int n = 0; n < 4; n++)
            s[4 * c + n] = gmul(a[n], 8'h02) ^ gmul(a[(n + 1) % 4], 8'h03) ^ a[(n + 2) % 4]
                           ^ a[(n + 3) % 4];
        end
      end
      for (int j = 0; j < 16; j++) s[j] ^= w[4 * r + j / 4][31 - 8 * (j % 4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127 - 8 * j -: 8] = s[j];
    return res;
  endfunction

  // ---------------- DUT access ----------------
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic drive(input int sel, input logic s, input logic [127:0] pt,
                       input logic [255:0] k);
    case (sel)
      0: begin b128.start = s; b128.in = pt; b128.key = k[127:0]; end
      1: begin b192.start = s; b192.in = pt; b192.key = k[191:0]; end
      default: begin b256.start = s; b256.in = pt; b256.key = k; end
    endcase
  endtask

  task automatic get(input int sel, output logic d, output logic b, output logic [127:0] o);
    case (sel)
      0: begin d = b128.done; b = b128.busy; o = b128.out; end
      1: begin d = b192.done; b = b192.busy; o = b192.out; end
      default: begin d = b256.done; b = b256.busy; o = b256.out; end
    endcase
  endtask

  task automatic add(input int sel, input logic [127:0] pt, input logic [255:0] k,
                     input logic [127:0] exp);
    q_pt.push_back(pt);
    q_key.push_back(k);
    q_exp.push_back(exp);
  endtask

  task automatic add_rand(input int sel);
    int           nk = 4 + 2 * sel;
    logic [127:0] pt = rnd128();
    logic [255:0] k  = rnd256();
    if (nk < 8) k = k & ((256'd1 << (32 * nk)) - 256'd1);
    add(sel, pt, k, aes_model(pt, k, nk));
  endtask

  // Runs all queued blocks back to back, each new start issued in the done cycle.
  // ign_at >= 0 pulses a bogus start at that cycle of every run.
  task automatic run(input int sel, input string tag, input int ign_at);
    int           nr = 10 + 2 * sel;
    int           n  = q_pt.size();
    int           d0 = dcnt[sel];
    int           lat;
    logic         d, b;
    logic [127:0] o;
    @(negedge clk);
    drive(sel, 1'b1, q_pt[0], q_key[0]);
    for (int k = 0; k < n; k++) begin
      for (lat = 0; lat < 40; lat++) begin
        @(negedge clk);
        if (lat == 0) drive(sel, 1'b0, rnd128(), rnd256());
        if (ign_at >= 0 && lat == ign_at) drive(sel, 1'b1, rnd128(), rnd256());
        if (ign_at >= 0 && lat == ign_at + 1) drive(sel, 1'b0, rnd128(), rnd256());
        get(sel, d, b, o);
        if (lat == 0) check($sformatf("%s[%0d] busy_after_start", tag, k), 128'(b), 128'(1));
        if (d) break;
      end
      check($sformatf("%s[%0d] latency", tag, k), 128'(lat), 128'(nr));
      check($sformatf("%s[%0d] out", tag, k), o, q_exp[k]);
      check($sformatf("%s[%0d] busy_at_done", tag, k), 128'(b), 128'(0));
      if (k + 1 < n) drive(sel, 1'b1, q_pt[k+1], q_key[k+1]);
    end
    repeat (nr + 3) @(negedge clk);
    get(sel, d, b, o);
    check($sformatf("%s done_pulses", tag), 128'(dcnt[sel] - d0), 128'(n));
    check($sformatf("%s out_hold", tag), o, q_exp[n-1]);
    check($sformatf("%s idle_busy", tag), 128'(b), 128'(0));
    q_pt.delete();
    q_key.delete();
    q_exp.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic         d, b;
    logic [127:0] o;
    int           d0;

    for (int i = 0; i < 256; i++) sb_t[i] = sbox_m(8'(i));

    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      get(s, d, b, o);
      check($sformatf("reset%0d out", s), o, '0);
      check($sformatf("reset%0d done", s), 128'(d), 128'(0));
      check($sformatf("reset%0d busy", s), 128'(b), 128'(0));
    end
    rst = 1'b0;

    add(0, 128'h3243f6a8885a308d313198a2e0370734, 256'(128'h2b7e151628aed2a6abf7158809cf4f3c),
        128'h3925841d02dc09fbdc118597196a0b32);
    run(0, "aes128_fips", -1);
    add(1, 128'h00112233445566778899aabbccddeeff,
        256'(192'h000102030405060708090a0b0c0d0e0f1011121314151617),
        128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    run(1, "aes192_vec", -1);
    add(2, 128'h00112233445566778899aabbccddeeff,
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
        128'h8ea2b7ca516745bfeafc49904b496089);
    run(2, "aes256_vec", -1);

    add(0, 128'h00112233445566778899aabbccddeeff, 256'(128'h000102030405060708090a0b0c0d0e0f),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run(0, "aes128_ignore", 3);

    add(0, 128'h00112233445566778899aabbccddeeff, 256'(128'h000102030405060708090a0b0c0d0e0f),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    repeat (3) add_rand(0);
    run(0, "b2b128", -1);
    repeat (3) add_rand(1);
    run(1, "b2b192", -1);
    repeat (2) add_rand(2);
    run(2, "b2b256", 5);

    // Abort an AES-256 run part way through.
    @(negedge clk);
    drive(2, 1'b1, rnd128(), rnd256());
    for (int lat = 0; lat < 5; lat++) begin
      @(negedge clk);
      if (lat == 0) drive(2, 1'b0, rnd128(), rnd256());
    end
    d0  = dcnt[2];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    get(2, d, b, o);
    check("abort out", o, '0);
    check("abort busy", 128'(b), 128'(0));
    check("abort done", 128'(d), 128'(0));
    repeat (16) @(negedge clk);
    check("abort no_done", 128'(dcnt[2] - d0), 128'(0));

    // Reset beats a simultaneous start.
    drive(0, 1'b1, rnd128(), rnd256());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1'b0, rnd128(), rnd256());
    get(0, d, b, o);
    check("rst_vs_start busy", 128'(b), 128'(0));
    @(negedge clk);
    get(0, d, b, o);
    check("rst_vs_start still_idle", 128'(b), 128'(0));

    add(2, 128'h00112233445566778899aabbccddeeff,
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
        128'h8ea2b7ca516745bfeafc49904b496089);
    add_rand(2);
    run(2, "aes256_after_abort", -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
